// File: rtl/lcd_cmd_arbiter_if.sv
// Command-port bundle between the two text requesters, the arbiter and the LCD driver.
// The arbiter connects through the slave modport; the requester/driver side uses master.
interface lcd_cmd_arbiter_if;
  logic [1:0] i_req;
  logic [1:0] i_wr_clear;
  logic [1:0] i_wr_line1;
  logic [1:0] i_wr_line2;
  logic       i_lcd_command_ready;
  logic [1:0] o_gnt;
  logic [1:0] o_cmd_ready;
  logic       o_lcd_wr_clear_display;
  logic       o_lcd_wr_text_line1;
  logic       o_lcd_wr_text_line2;
  logic       o_text_sel;
  logic       o_lcd_fault;
  logic       o_arb_idle;

  modport slave (
    input  i_req, i_wr_clear, i_wr_line1, i_wr_line2, i_lcd_command_ready,
    output o_gnt, o_cmd_ready, o_lcd_wr_clear_display, o_lcd_wr_text_line1,
           o_lcd_wr_text_line2, o_text_sel, o_lcd_fault, o_arb_idle
  );

  modport master (
    output i_req, i_wr_clear, i_wr_line1, i_wr_line2, i_lcd_command_ready,
    input  o_gnt, o_cmd_ready, o_lcd_wr_clear_display, o_lcd_wr_text_line1,
           o_lcd_wr_text_line2, o_text_sel, o_lcd_fault, o_arb_idle
  );
endinterface

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin, frame-granular arbiter sharing one LCD driver command port between two
// text requesters, with a busy watchdog that revokes a stalled grant and flags a sticky fault.
module lcd_cmd_arbiter #(
  parameter int unsigned parm_fast_simulation = 0,
  parameter int unsigned parm_busy_limit      = 250000
) (
  input  logic              i_clk_20mhz,
  input  logic              i_rst_20mhz,
  input  logic              i_ce_2_5mhz,
  lcd_cmd_arbiter_if.slave  io_bus
);
  localparam int unsigned WDOG_W = 24;
  localparam int unsigned LIMIT  = (parm_fast_simulation != 0) ? 2500 : parm_busy_limit;
  localparam logic [WDOG_W-1:0] LIMIT_M1  = WDOG_W'(LIMIT - 1);
  localparam logic [WDOG_W-1:0] LIMIT_SAT = WDOG_W'(LIMIT);

  typedef enum logic [1:0] {
    ST_ARB_IDLE  = 2'd0,
    ST_ARB_GNT0  = 2'd1,
    ST_ARB_GNT1  = 2'd2,
    ST_ARB_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_ptr, w_ptr_nxt;
  logic              r_text_sel, w_text_sel_nxt;
  logic              r_fault, w_fault_nxt;
  logic [WDOG_W-1:0] r_wdog, w_wdog_nxt;
  logic [1:0]        r_gnt;
  logic              w_win;
  logic              w_owner;
  logic              w_busy_st;
  logic              w_limit_hit;

  // State and bookkeeping registers; everything advances only on ce ticks via the next-state logic
  always_ff @(posedge i_clk_20mhz or posedge i_rst_20mhz) begin
    if (i_rst_20mhz) begin
      r_state    <= ST_ARB_IDLE;
      r_ptr      <= 1'b0;
      r_text_sel <= 1'b0;
      r_fault    <= 1'b0;
      r_wdog     <= '0;
      r_gnt      <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_text_sel <= w_text_sel_nxt;
      r_fault    <= w_fault_nxt;
      r_wdog     <= w_wdog_nxt;
      r_gnt      <= {w_state_nxt == ST_ARB_GNT1, w_state_nxt == ST_ARB_GNT0};
    end
  end

  // Next-state, round-robin pointer and watchdog
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_text_sel_nxt = r_text_sel;
    w_fault_nxt    = r_fault;
    w_wdog_nxt     = r_wdog;
    w_win          = 1'b0;
    w_owner        = (r_state == ST_ARB_GNT1);
    w_busy_st      = (r_state != ST_ARB_IDLE);
    w_limit_hit    = w_busy_st && !io_bus.i_lcd_command_ready && (r_wdog == LIMIT_M1);

    if (i_ce_2_5mhz) begin
      case (r_state)
        ST_ARB_IDLE: begin
          if (io_bus.i_lcd_command_ready && (io_bus.i_req != 2'b00)) begin
            w_win          = io_bus.i_req[r_ptr] ? r_ptr : ~r_ptr;
            w_state_nxt    = w_win ? ST_ARB_GNT1 : ST_ARB_GNT0;
            w_ptr_nxt      = ~w_win;
            w_text_sel_nxt = w_win;
          end
        end
        ST_ARB_GNT0, ST_ARB_GNT1: begin
          if (w_limit_hit || !io_bus.i_req[w_owner]) w_state_nxt = ST_ARB_DRAIN;
        end
        ST_ARB_DRAIN: begin
          if (io_bus.i_lcd_command_ready || w_limit_hit) w_state_nxt = ST_ARB_IDLE;
        end
        default: w_state_nxt = ST_ARB_IDLE;
      endcase

      if (w_limit_hit) w_fault_nxt = 1'b1;

      if ((w_state_nxt != r_state) || io_bus.i_lcd_command_ready) begin
        w_wdog_nxt = '0;
      end else if (w_busy_st && (r_wdog != LIMIT_SAT)) begin
        w_wdog_nxt = r_wdog + WDOG_W'(1);
      end
    end
  end

  // Owner-only routing; r_gnt is all-zero outside GNTn so nothing leaks in IDLE or DRAIN
  assign io_bus.o_gnt                  = r_gnt;
  assign io_bus.o_cmd_ready            = r_gnt & {2{io_bus.i_lcd_command_ready}};
  assign io_bus.o_lcd_wr_clear_display = |(r_gnt & io_bus.i_wr_clear);
  assign io_bus.o_lcd_wr_text_line1    = |(r_gnt & io_bus.i_wr_line1);
  assign io_bus.o_lcd_wr_text_line2    = |(r_gnt & io_bus.i_wr_line2);
  assign io_bus.o_text_sel             = r_text_sel;
  assign io_bus.o_lcd_fault            = r_fault;
  assign io_bus.o_arb_idle             = (r_state == ST_ARB_IDLE);
endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed bench for lcd_cmd_arbiter: table of per-tick vectors plus hand sequences
// for round-robin from reset, busy driver at request, watchdog timeout and async reset.
module tb_lcd_cmd_arbiter;
  logic clk;
  logic rst;
  logic ce;
  int   n_total;
  int   n_bad;

  lcd_cmd_arbiter_if bus ();

  lcd_cmd_arbiter #(
    .parm_fast_simulation (1),
    .parm_busy_limit      (250000)
  ) dut (
    .i_clk_20mhz (clk),
    .i_rst_20mhz (rst),
    .i_ce_2_5mhz (ce),
    .io_bus      (bus)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  typedef struct {
    logic [1:0] req;
    logic [1:0] clr;
    logic [1:0] l1;
    logic [1:0] l2;
    logic       rdy;
    logic [1:0] gnt;
    logic [1:0] crdy;
    logic [2:0] strb;
    logic       sel;
    logic       idle;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setin(input logic [1:0] req, input logic [1:0] clr, input logic [1:0] l1,
                       input logic [1:0] l2, input logic rdy);
    bus.i_req               = req;
    bus.i_wr_clear          = clr;
    bus.i_wr_line1          = l1;
    bus.i_wr_line2          = l2;
    bus.i_lcd_command_ready = rdy;
  endtask

  // One ce tick across a posedge, then a gap cycle with ce low; returns at a negedge
  task automatic tick();
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [2:0] strobes();
    return {bus.o_lcd_wr_clear_display, bus.o_lcd_wr_text_line1, bus.o_lcd_wr_text_line2};
  endfunction

  initial begin
    n_total = 0;
    n_bad   = 0;
    ce      = 1'b0;
    rst     = 1'b1;
    setin(2'b00, 2'b00, 2'b00, 2'b00, 1'b0);

    //            req    clr    l1     l2     rdy    gnt    crdy   strb    sel   idle
    vecs[0]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 2'b01, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 3'b100, 1'b0, 1'b0};
    vecs[2]  = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 2'b01, 2'b00, 3'b000, 1'b0, 1'b0};
    vecs[3]  = '{2'b01, 2'b00, 2'b01, 2'b00, 1'b1, 2'b01, 2'b01, 3'b010, 1'b0, 1'b0};
    vecs[4]  = '{2'b11, 2'b00, 2'b10, 2'b01, 1'b1, 2'b01, 2'b01, 3'b001, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
    vecs[6]  = '{2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
    vecs[7]  = '{2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1};
    vecs[8]  = '{2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 3'b000, 1'b1, 1'b0};
    vecs[9]  = '{2'b10, 2'b00, 2'b00, 2'b10, 1'b1, 2'b10, 2'b10, 3'b001, 1'b1, 1'b0};
    vecs[10] = '{2'b11, 2'b01, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 3'b000, 1'b1, 1'b0};
    vecs[11] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0};
    vecs[12] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1};
    vecs[13] = '{2'b01, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0};
    vecs[14] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
    vecs[15] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1};
    vecs[16] = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'b10, 2'b10, 3'b000, 1'b1, 1'b0};
    vecs[17] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0};
    vecs[18] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 1'b1, 1'b1};
    vecs[19] = '{2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0};
    vecs[20] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0};
    vecs[21] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1};

    do_reset();
    chk("reset gnt",   32'(bus.o_gnt), 32'h0);
    chk("reset crdy",  32'(bus.o_cmd_ready), 32'h0);
    chk("reset strb",  32'(strobes()), 32'h0);
    chk("reset sel",   32'(bus.o_text_sel), 32'h0);
    chk("reset fault", 32'(bus.o_lcd_fault), 32'h0);
    chk("reset idle",  32'(bus.o_arb_idle), 32'h1);

    for (int i = 0; i < 22; i++) begin
      setin(vecs[i].req, vecs[i].clr, vecs[i].l1, vecs[i].l2, vecs[i].rdy);
      tick();
      chk($sformatf("v%0d gnt", i),  32'(bus.o_gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d crdy", i), 32'(bus.o_cmd_ready), 32'(vecs[i].crdy));
      chk($sformatf("v%0d strb", i), 32'(strobes()), 32'(vecs[i].strb));
      chk($sformatf("v%0d sel", i),  32'(bus.o_text_sel), 32'(vecs[i].sel));
      chk($sformatf("v%0d idle", i), 32'(bus.o_arb_idle), 32'(vecs[i].idle));
    end

    // Simultaneous request straight out of reset goes to requester 0, then 1, then 0 again
    do_reset();
    setin(2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    chk("rr first gnt", 32'(bus.o_gnt), 32'h1);
    setin(2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    tick();
    chk("rr idle", 32'(bus.o_arb_idle), 32'h1);
    tick();
    chk("rr second gnt", 32'(bus.o_gnt), 32'h2);
    setin(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    tick();
    setin(2'b11, 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    chk("rr third gnt", 32'(bus.o_gnt), 32'h1);

    // Driver busy while requested: no grant until the first ready tick
    do_reset();
    setin(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("busy%0d gnt", i), 32'(bus.o_gnt), 32'h0);
    end
    chk("busy idle", 32'(bus.o_arb_idle), 32'h1);
    bus.i_lcd_command_ready = 1'b1;
    tick();
    chk("busy then gnt", 32'(bus.o_gnt), 32'h1);

    // Watchdog: 2500 busy ticks revoke GNT1, another 2500 end DRAIN
    do_reset();
    setin(2'b10, 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    chk("wd gnt1", 32'(bus.o_gnt), 32'h2);
    bus.i_lcd_command_ready = 1'b0;
    repeat (2499) tick();
    chk("wd gnt before limit", 32'(bus.o_gnt), 32'h2);
    chk("wd fault before limit", 32'(bus.o_lcd_fault), 32'h0);
    tick();
    chk("wd gnt revoked", 32'(bus.o_gnt), 32'h0);
    chk("wd fault set", 32'(bus.o_lcd_fault), 32'h1);
    chk("wd in drain", 32'(bus.o_arb_idle), 32'h0);
    repeat (2499) tick();
    chk("wd drain before limit", 32'(bus.o_arb_idle), 32'h0);
    tick();
    chk("wd drain timeout idle", 32'(bus.o_arb_idle), 32'h1);
    chk("wd fault sticky", 32'(bus.o_lcd_fault), 32'h1);
    bus.i_lcd_command_ready = 1'b1;
    tick();
    chk("wd regrant with fault", 32'(bus.o_gnt), 32'h2);

    // Move ownership to requester 0, then reset mid-frame with line-2 strobe active
    setin(2'b01, 2'b00, 2'b00, 2'b00, 1'b1);
    tick();
    tick();
    tick();
    chk("mr gnt0", 32'(bus.o_gnt), 32'h1);
    bus.i_wr_line2 = 2'b01;
    #1;
    chk("mr l2 active", 32'(strobes()), 32'h1);
    chk("mr fault before", 32'(bus.o_lcd_fault), 32'h1);
    #5 rst = 1'b1;
    #1;
    chk("mr gnt", 32'(bus.o_gnt), 32'h0);
    chk("mr crdy", 32'(bus.o_cmd_ready), 32'h0);
    chk("mr strb", 32'(strobes()), 32'h0);
    chk("mr sel", 32'(bus.o_text_sel), 32'h0);
    chk("mr fault", 32'(bus.o_lcd_fault), 32'h0);
    chk("mr idle", 32'(bus.o_arb_idle), 32'h1);
    #5 rst = 1'b0;
    #1;
    chk("mr strb after release", 32'(strobes()), 32'h0);
    @(negedge clk);
    chk("mr no cmd without tick", 32'(strobes()), 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
